// File: rtl/fft_butterfly_scheduler.sv
// ============================================================================
// Module   : fft_butterfly_scheduler
// Function : In-place radix-2 FFT butterfly address/twiddle sequencer with a
//            drain gap per stage and a delayed write-address pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_butterfly_scheduler #(
    parameter int N_POINTS = 32,
    parameter int PIPE_LAT = 1,
    localparam int ADDR_W = $clog2(N_POINTS),
    localparam int STAGES = ADDR_W,
    localparam int SW     = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_even,
    output logic [ADDR_W-1:0] rd_addr_odd,
    output logic [ADDR_W-2:0] twiddle_idx,
    output logic              base_case,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_low,
    output logic [ADDR_W-1:0] wr_addr_high,
    output logic [SW-1:0]     stage
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int              BW           = ADDR_W - 1;
    localparam logic [BW-1:0]   c_last_b     = BW'(N_POINTS / 2 - 1);
    localparam logic [SW-1:0]   c_last_stage = SW'(STAGES - 1);
    localparam logic [2:0]      c_last_drain = 3'(PIPE_LAT - 1);

    state_t            r_state, w_state_nxt;
    logic [BW-1:0]     r_b, w_b_nxt;
    logic [SW-1:0]     w_stage_nxt;
    logic [2:0]        r_dcnt, w_dcnt_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_stage_nxt = stage;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_b_nxt     = '0;
                    w_stage_nxt = '0;
                end
            end
            S_RUN: begin
                if (r_b == c_last_b) begin
                    w_state_nxt = S_DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_b_nxt = r_b + BW'(1);
                end
            end
            S_DRAIN: begin
                if (r_dcnt == c_last_drain) begin
                    w_b_nxt = '0;
                    if (stage == c_last_stage) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_stage_nxt = stage + SW'(1);
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_b_nxt     = '0;
                w_stage_nxt = '0;
            end
        endcase
    end

    // Issue outputs are computed from the next-state values so they can be
    // registered and still line up with the state they describe.
    logic [ADDR_W-1:0] w_bx, w_mask, w_k, w_even, w_odd, w_tw_full;
    logic [SW-1:0]     w_tw_sh;
    logic              w_issue;

    always_comb begin
        w_bx      = {1'b0, w_b_nxt};
        w_mask    = (ADDR_W'(1) << w_stage_nxt) - ADDR_W'(1);
        w_k       = w_bx & w_mask;
        w_even    = ((w_bx & ~w_mask) << 1) | w_k;
        w_odd     = w_even | (ADDR_W'(1) << w_stage_nxt);
        w_tw_sh   = c_last_stage - w_stage_nxt;
        w_tw_full = w_k << w_tw_sh;
        w_issue   = (w_state_nxt == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_b          <= '0;
            r_dcnt       <= '0;
            stage        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr_even <= '0;
            rd_addr_odd  <= '0;
            twiddle_idx  <= '0;
            base_case    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_b          <= w_b_nxt;
            r_dcnt       <= w_dcnt_nxt;
            stage        <= w_stage_nxt;
            busy         <= (w_state_nxt != S_IDLE);
            done         <= (w_state_nxt == S_DONE);
            rd_en        <= w_issue;
            rd_addr_even <= w_issue ? w_even : '0;
            rd_addr_odd  <= w_issue ? w_odd : '0;
            twiddle_idx  <= w_issue ? w_tw_full[ADDR_W-2:0] : '0;
            base_case    <= w_issue && (w_stage_nxt == '0);
        end
    end

    // Write-side shift pipeline; cleared by reset so in-flight reads never
    // turn into writes after an abort.
    logic              r_pen [PIPE_LAT];
    logic [ADDR_W-1:0] r_pev [PIPE_LAT];
    logic [ADDR_W-1:0] r_pod [PIPE_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pen[i] <= 1'b0;
                r_pev[i] <= '0;
                r_pod[i] <= '0;
            end
        end else begin
            r_pen[0] <= rd_en;
            r_pev[0] <= rd_addr_even;
            r_pod[0] <= rd_addr_odd;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pen[i] <= r_pen[i-1];
                r_pev[i] <= r_pev[i-1];
                r_pod[i] <= r_pod[i-1];
            end
        end
    end

    assign wr_en        = r_pen[PIPE_LAT-1];
    assign wr_addr_low  = r_pev[PIPE_LAT-1];
    assign wr_addr_high = r_pod[PIPE_LAT-1];

endmodule

`default_nettype wire
